// File: rtl/uart_mem_bridge_if.sv
// Synchronous single-port BRAM bus between the UART bridge (master) and the memory (slave).
interface uart_mem_bridge_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();
  logic [ADDR_W-1:0] addr_io;
  logic [DATA_W-1:0] data_out_io;
  logic [DATA_W-1:0] data_in_io;
  logic              we_io;

  modport master (
    output addr_io,
    output data_out_io,
    output we_io,
    input  data_in_io
  );

  modport slave (
    input  addr_io,
    input  data_out_io,
    input  we_io,
    output data_in_io
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// Moves LEN words between a UART line and a BRAM: receive packs 8N1 bytes into words and
// writes them from BASE upward; send reads words from BASE upward and shifts them out.
module uart_mem_bridge #(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              rx,
  output logic              tx,
  input  logic              ctrl_io_receive,
  input  logic              ctrl_io_send,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  uart_mem_bridge_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic              led_rx,
  output logic              led_tx
);

  localparam int unsigned DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned BW      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned LW      = $clog2(READ_LAT + 2);

  typedef enum logic [2:0] {
    StIdle, StRxByte, StRxWrite, StTxRead, StTxShift, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     tick_cnt_q;
  logic              tick, tick_clr;
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  logic              rx_active_q, rx_active_d;
  logic [3:0]        os_cnt_q, os_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]     byte_idx_q, byte_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [DATA_W-1:0] word_q, word_d, merged;
  logic [7:0]        cur_byte;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              we_q, we_d;
  logic              tx_q, tx_d;
  logic              frame_err_q, frame_err_d;
  logic              led_rx_q, led_rx_d, led_tx_q, led_tx_d;

  assign tick = (tick_cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Restarted on an RX start edge and at each TX word so bit timing is exact.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick_clr || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CW'(1);
    end
  end

  always_comb begin
    merged   = word_q;
    cur_byte = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (byte_idx_q == BW'(b)) begin
        merged[b*8 +: 8] = shift_q;
        cur_byte         = word_q[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_clr    = 1'b0;
    rx_active_d = rx_active_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    word_d      = word_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    we_d        = 1'b0;
    tx_d        = tx_q;
    frame_err_d = frame_err_q;
    led_rx_d    = led_rx_q;
    led_tx_d    = led_tx_q;

    unique case (state_q)
      StIdle: begin
        if (ctrl_io_receive || ctrl_io_send) begin
          base_d      = base_addr;
          len_d       = len;
          idx_d       = '0;
          byte_idx_d  = '0;
          rx_active_d = 1'b0;
          frame_err_d = 1'b0;
          if (len == '0) begin
            state_d = StDone;
          end else if (ctrl_io_receive) begin
            state_d = StRxByte;
          end else begin
            state_d = StTxRead;
            addr_d  = base_addr;
            lat_d   = '0;
          end
        end
      end

      StRxByte: begin
        if (!rx_active_q) begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_active_d = 1'b1;
            tick_clr    = 1'b1;
            os_cnt_d    = 4'd8;  // first sample lands 8 ticks in: middle of the start bit
            bit_cnt_d   = '0;
          end
        end else if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'hF) begin
            if (bit_cnt_q == 4'd0) begin
              if (rx_sync_q) rx_active_d = 1'b0;
              else           bit_cnt_d   = 4'd1;
            end else if (bit_cnt_q < 4'd9) begin
              shift_d   = {rx_sync_q, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              rx_active_d = 1'b0;
              if (!rx_sync_q) begin
                frame_err_d = 1'b1;
              end else begin
                led_rx_d = ~led_rx_q;
                word_d   = merged;
                if (byte_idx_q == BW'(BYTES - 1)) begin
                  byte_idx_d = '0;
                  addr_d     = base_q + idx_q;
                  dout_d     = merged;
                  we_d       = 1'b1;
                  state_d    = StRxWrite;
                end else begin
                  byte_idx_d = byte_idx_q + BW'(1);
                end
              end
            end
          end
        end
      end

      StRxWrite: begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = (idx_q + ADDR_W'(1) == len_q) ? StDone : StRxByte;
      end

      StTxRead: begin
        if (lat_q == LW'(READ_LAT)) begin
          word_d     = mem.data_in_io;
          byte_idx_d = '0;
          bit_cnt_d  = '0;
          os_cnt_d   = '0;
          tick_clr   = 1'b1;
          tx_d       = 1'b0;
          state_d    = StTxShift;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end

      StTxShift: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'hF) begin
            if (bit_cnt_q < 4'd8) begin
              tx_d      = cur_byte[bit_cnt_q[2:0]];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              tx_d      = 1'b1;
              bit_cnt_d = 4'd9;
            end else begin
              led_tx_d = ~led_tx_q;
              if (byte_idx_q != BW'(BYTES - 1)) begin
                byte_idx_d = byte_idx_q + BW'(1);
                bit_cnt_d  = '0;
                tx_d       = 1'b0;
              end else begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q + ADDR_W'(1) == len_q) begin
                  state_d = StDone;
                end else begin
                  state_d = StTxRead;
                  addr_d  = base_q + idx_q + ADDR_W'(1);
                  lat_d   = '0;
                end
              end
            end
          end
        end
      end

      StDone: begin
        if (!ctrl_io_receive && !ctrl_io_send) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rx_active_q <= 1'b0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      we_q        <= 1'b0;
      tx_q        <= 1'b1;
      frame_err_q <= 1'b0;
      led_rx_q    <= 1'b0;
      led_tx_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_active_q <= rx_active_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      we_q        <= we_d;
      tx_q        <= tx_d;
      frame_err_q <= frame_err_d;
      led_rx_q    <= led_rx_d;
      led_tx_q    <= led_tx_d;
    end
  end

  assign tx              = tx_q;
  assign mem.addr_io     = addr_q;
  assign mem.data_out_io = dout_q;
  assign mem.we_io       = we_q;
  assign busy            = (state_q != StIdle) && (state_q != StDone);
  assign done            = (state_q == StDone);
  assign frame_err       = frame_err_q;
  assign led_rx          = led_rx_q;
  assign led_tx          = led_tx_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Bench for uart_mem_bridge: drives UART frames and BRAM, predicts writes and line frames.
module tb_uart_mem_bridge;
  localparam int unsigned CLK_HZ   = 3200000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned READ_LAT = 2;
  localparam int BIT = 32;  // 16 ticks x round(3.2e6 / 1.6e6) = 2 cycles per tick

  logic        clk_100 = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        ctrl_io_receive = 1'b0;
  logic        ctrl_io_send = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] len = '0;
  logic        tx, busy, done, frame_err, led_rx, led_tx;

  uart_mem_bridge_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

  uart_mem_bridge #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(16), .DATA_W(16), .READ_LAT(READ_LAT)
  ) dut (
    .clk_100(clk_100), .rst_n(rst_n), .rx(rx), .tx(tx),
    .ctrl_io_receive(ctrl_io_receive), .ctrl_io_send(ctrl_io_send),
    .base_addr(base_addr), .len(len), .mem(mem_if),
    .busy(busy), .done(done), .frame_err(frame_err), .led_rx(led_rx), .led_tx(led_tx)
  );

  always #5 clk_100 = ~clk_100;

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural BRAM with READ_LAT-cycle read latency; bench preload has priority.
  logic [15:0] mem_arr [65536];
  logic [15:0] rd_pipe [READ_LAT];
  logic        pre_we = 1'b0;
  logic [15:0] pre_a = '0, pre_d = '0;
  assign mem_if.data_in_io = rd_pipe[READ_LAT-1];
  always @(posedge clk_100) begin
    rd_pipe[0] <= mem_arr[mem_if.addr_io];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (pre_we) mem_arr[pre_a] <= pre_d;
    else if (mem_if.we_io) mem_arr[mem_if.addr_io] <= mem_if.data_out_io;
  end

  typedef struct packed {logic [15:0] a; logic [15:0] d;} wr_t;
  typedef struct packed {logic [7:0] b; logic contig;} txe_t;
  wr_t         exp_wr[$];
  txe_t        exp_tx[$];
  logic [7:0]  tx_log[$];
  int          rx_toggles = 0, tx_toggles = 0;
  logic [15:0] exp_addr = '0;

  // Every write pulse must match the next predicted write.
  always @(negedge clk_100) begin
    if (rst_n && mem_if.we_io === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL write_unexpected: addr 0x%0h data 0x%0h, expected no write",
                 mem_if.addr_io, mem_if.data_out_io);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("write_addr", mem_if.addr_io, w.a);
        chk("write_data", mem_if.data_out_io, w.d);
      end
    end
  end

  // Line decoder: each bit must be stable from its 2nd to its last cycle.
  initial begin : tx_mon
    logic prev;
    int   start_cyc, last_start, off;
    logic [9:0] bits;
    logic stable;
    txe_t e;
    prev = 1'b1;
    last_start = -100000;
    forever begin
      @(negedge clk_100);
      if (!rst_n) begin
        prev = 1'b1;
      end else if (prev && tx === 1'b0) begin
        start_cyc = cyc;
        stable = 1'b1;
        off = 0;
        for (int b = 0; b < 10; b++) begin
          logic s0;
          repeat (b * BIT + 1 - off) @(negedge clk_100);
          s0 = tx;
          repeat (BIT - 2) @(negedge clk_100);
          off = b * BIT + BIT - 1;
          if (tx !== s0) stable = 1'b0;
          bits[b] = s0;
        end
        prev = tx;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: frame byte 0x%0h, expected no frame", bits[8:1]);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_frame", {21'd0, bits[9], bits[8:1], bits[0], stable},
              {21'd0, 1'b1, e.b, 1'b0, 1'b1});
          if (e.contig) chk("tx_gap", start_cyc - last_start, 10 * BIT);
        end
        tx_log.push_back(bits[8:1]);
        last_start = start_cyc;
      end else begin
        prev = tx;
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk_100);
    pre_we = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    logic [9:0] fr;
    fr = {good ? 1'b1 : 1'b0, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (BIT) @(negedge clk_100);
    end
    rx = 1'b1;
    repeat (4 + $urandom_range(0, 20)) @(negedge clk_100);
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk_100);
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_tx", tx, 1); chk("rst_we", mem_if.we_io, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_ferr", frame_err, 0); chk("rst_led_rx", led_rx, 0);
    chk("rst_led_tx", led_tx, 0); chk("rst_addr", mem_if.addr_io, 0);
    chk("rst_dout", mem_if.data_out_io, 0);
  endtask

  task automatic finish_xfer(input bit held);
    if (held) begin
      repeat (3) @(negedge clk_100);
      chk("done_held", done, 1);
      chk("busy_low_in_done", busy, 0);
    end
    ctrl_io_receive = 1'b0;
    ctrl_io_send = 1'b0;
    repeat (2) @(negedge clk_100);
    chk("done_cleared", done, 0);
  endtask

  task automatic run_rx(input logic [15:0] base, input logic [15:0] n,
                        input logic [7:0] bytes[$], input bit good[$], input bit both);
    logic [7:0] pk[$];
    bit any_bad;
    any_bad = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      if (good[i]) begin pk.push_back(bytes[i]); rx_toggles++; end
      else any_bad = 1'b1;
    end
    for (int w = 0; w < int'(n); w++)
      exp_wr.push_back(wr_t'{base + 16'(w), {pk[2*w+1], pk[2*w]}});
    base_addr = base; len = n; ctrl_io_receive = 1'b1; ctrl_io_send = both;
    @(negedge clk_100);
    chk("rx_busy", busy, 1);
    chk("rx_ferr_cleared", frame_err, 0);
    base_addr = ~base; len = 16'h0;
    for (int i = 0; i < bytes.size(); i++) send_byte(bytes[i], good[i]);
    wait_done(200);
    exp_addr = base + n - 16'd1;
    chk("rx_writes_all", exp_wr.size(), 0);
    chk("rx_ferr", frame_err, any_bad);
    chk("rx_addr_final", mem_if.addr_io, exp_addr);
    chk("led_rx", led_rx, rx_toggles & 1);
    finish_xfer(1'b1);
  endtask

  task automatic run_tx(input logic [15:0] base, input logic [15:0] vals[$], input bit drop);
    logic [15:0] n;
    n = 16'(vals.size());
    for (int w = 0; w < vals.size(); w++) begin
      preload(base + 16'(w), vals[w]);
      exp_tx.push_back(txe_t'{vals[w][7:0], 1'b0});
      exp_tx.push_back(txe_t'{vals[w][15:8], 1'b1});
      tx_toggles += 2;
    end
    base_addr = base; len = n; ctrl_io_send = 1'b1;
    @(negedge clk_100);
    chk("tx_busy", busy, 1);
    chk("tx_ferr_cleared", frame_err, 0);
    base_addr = ~base; len = 16'h0;
    if (drop) ctrl_io_send = 1'b0;
    wait_done(int'(n) * (20 * BIT + READ_LAT + 8) + 50);
    exp_addr = base + n - 16'd1;
    chk("tx_frames_all", exp_tx.size(), 0);
    chk("tx_addr_final", mem_if.addr_io, exp_addr);
    chk("led_tx", led_tx, tx_toggles & 1);
    finish_xfer(!drop);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0]  bq[$];
    bit          gq[$];
    logic [15:0] vq[$];
    repeat (3) @(negedge clk_100);
    check_reset_vals();
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100);

    // Two words from four bytes, low byte first.
    bq = '{8'h0F, 8'hF0, 8'h55, 8'hAA}; gq = '{1, 1, 1, 1};
    run_rx(16'h0010, 16'd2, bq, gq, 1'b0);
    chk("lit_mem_0010", mem_arr[16'h0010], 16'hF00F);
    chk("lit_mem_0011", mem_arr[16'h0011], 16'hAA55);

    // Bad stop bit: byte dropped, packing restarts at byte 0.
    bq = '{8'h3C, 8'h01, 8'h02}; gq = '{0, 1, 1};
    run_rx(16'h0030, 16'd1, bq, gq, 1'b0);
    chk("lit_mem_0030", mem_arr[16'h0030], 16'h0201);

    // Send one word.
    tx_log.delete();
    vq = '{16'hA55A};
    run_tx(16'h0020, vq, 1'b0);
    chk("lit_tx_byte0", tx_log.size() > 0 ? tx_log[0] : 8'hxx, 8'h5A);
    chk("lit_tx_byte1", tx_log.size() > 1 ? tx_log[1] : 8'hxx, 8'hA5);

    // len=0 send: done at once, no bus or line activity.
    len = 16'h0; base_addr = 16'h1234; ctrl_io_send = 1'b1;
    repeat (2) begin
      @(negedge clk_100);
      chk("len0_we", mem_if.we_io, 0);
      chk("len0_tx", tx, 1);
      chk("len0_addr", mem_if.addr_io, exp_addr);
    end
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    finish_xfer(1'b0);

    // Reset in the middle of the second byte of a word.
    base_addr = 16'h0000; len = 16'd1; ctrl_io_receive = 1'b1;
    @(negedge clk_100);
    send_byte(8'h77, 1'b1);
    rx = 1'b0; repeat (BIT) @(negedge clk_100);
    rx = 1'b1; repeat (3 * BIT) @(negedge clk_100);
    rst_n = 1'b0; ctrl_io_receive = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk_100);
    rst_n = 1'b1;
    rx_toggles = 0; tx_toggles = 0; exp_addr = '0;
    repeat (2) @(negedge clk_100);
    bq = '{8'h12, 8'h34}; gq = '{1, 1};
    run_rx(16'h0000, 16'd1, bq, gq, 1'b0);
    chk("lit_mem_0000_fresh", mem_arr[16'h0000], 16'h3412);

    // Address wrap, both ctrl high selects receive.
    bq = '{8'h11, 8'h22, 8'h33, 8'h44}; gq = '{1, 1, 1, 1};
    run_rx(16'hFFFF, 16'd2, bq, gq, 1'b1);
    chk("lit_mem_ffff", mem_arr[16'hFFFF], 16'h2211);
    chk("lit_mem_0000_wrap", mem_arr[16'h0000], 16'h4433);

    // Randomised transfers.
    for (int it = 0; it < 6; it++) begin
      logic [15:0] base, n;
      base = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      n = 16'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        int ng;
        bq.delete(); gq.delete(); ng = 0;
        while (ng < 2 * int'(n)) begin
          bit g;
          g = ($urandom_range(0, 5) != 0);
          bq.push_back(8'($urandom)); gq.push_back(g);
          if (g) ng++;
        end
        run_rx(base, n, bq, gq, 1'($urandom_range(0, 1)));
      end else begin
        vq.delete();
        for (int w = 0; w < int'(n); w++) vq.push_back(16'($urandom));
        run_tx(base, vq, 1'($urandom_range(0, 1)));
      end
    end

    repeat (10) @(negedge clk_100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
